mem_access_sequencer: RTL and testbench

Single-outstanding load/store sequencer between the execute stage and `memory_unit`. It converts RV32 byte, halfword and word accesses into word-wide `memory_unit` transactions, and waits on `memory_unit` ready/valid. Sub-word stores are done as read-modify-write. Load results are returned to writeback already extracted and sign- or zero-extended, together with the destination tag.

---
 rtl/mem_seq_pkg.sv | 29 ++
 rtl/byte_lane_align.sv | 50 +++++
 rtl/mem_access_sequencer.sv | 138 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared encodings, state type and request error check for the load/store sequencer
package mem_seq_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_REQ   = 3'd1,
        LD_WAIT  = 3'd2,
        RMW_REQ  = 3'd3,
        RMW_WAIT = 3'd4,
        ST_REQ   = 3'd5,
        RESP     = 3'd6
    } seq_state_t;

    // A request is rejected without touching memory when it is both a load and a store,
    // uses the reserved size, or is not naturally aligned for its size.
    function automatic logic req_error(input logic is_load, input logic is_store,
                                       input logic [1:0] size, input logic [1:0] addr_lo);
        return (is_load & is_store)
            | (size == SIZE_RSVD)
            | ((size == SIZE_HALF) & addr_lo[0])
            | ((size == SIZE_WORD) & (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - combinational load lane extraction/extension and sub-word store merge
module byte_lane_align
    import mem_seq_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [4:0]  w_byte_shift;
    logic [4:0]  w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_byte_mask;
    logic [31:0] w_half_mask;

    assign w_byte_shift = {i_offset, 3'b000};
    assign w_half_shift = {i_offset[1], 4'b0000};

    // Pick the addressed lane out of the memory word and extend it to a full register value
    always_comb begin
        w_byte      = i_word[w_byte_shift +: 8];
        w_half      = i_word[w_half_shift +: 16];
        o_load_data = i_word;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_load_data = i_word;
        endcase
    end

    // Replace the addressed lane of the old word with the right-justified store data
    always_comb begin
        w_byte_mask   = 32'h0000_00FF << w_byte_shift;
        w_half_mask   = 32'h0000_FFFF << w_half_shift;
        o_merged_word = i_store_data;
        case (i_size)
            SIZE_BYTE: o_merged_word = (i_word & ~w_byte_mask)
                                     | ({24'd0, i_store_data[7:0]} << w_byte_shift);
            SIZE_HALF: o_merged_word = (i_word & ~w_half_mask)
                                     | ({16'd0, i_store_data[15:0]} << w_half_shift);
            default:   o_merged_word = i_store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - single-outstanding RV32 load/store sequencer in front of memory_unit
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int TAG_BITS     = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_load,
    input  logic                    req_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_BITS-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]   req_store_data,
    input  logic [TAG_BITS-1:0]     req_tag,
    output logic                    mem_load,
    output logic                    mem_store,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_store_data,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [DATA_WIDTH-1:0]   mem_load_data,
    input  logic [ADDRESS_BITS-1:0] mem_data_addr,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [TAG_BITS-1:0]     rsp_tag,
    output logic                    rsp_error,
    output logic                    busy
);

    seq_state_t                r_state;
    seq_state_t                w_next;
    logic [ADDRESS_BITS-1:0]   r_addr;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic [DATA_WIDTH-1:0]     r_store_word;
    logic [TAG_BITS-1:0]       r_tag;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic                      r_rsp_error;

    logic                      w_req_err;
    logic                      w_mem_hit;
    logic [ADDRESS_BITS-1:0]   w_mem_address;
    logic [DATA_WIDTH-1:0]     w_load_data;
    logic [DATA_WIDTH-1:0]     w_merged;

    assign w_req_err     = req_error(req_load, req_store, req_size, req_address[1:0]);
    assign w_mem_address = {r_addr[ADDRESS_BITS-1:2], 2'b00};
    // Read data only counts when its echoed address is the word we asked for
    assign w_mem_hit     = mem_valid && (mem_data_addr == w_mem_address);

    byte_lane_align u_align (
        .i_word        (mem_load_data),
        .i_offset      (r_addr[1:0]),
        .i_size        (r_size),
        .i_unsigned    (r_unsigned),
        .i_store_data  (r_store_word),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: route accepted requests to the error, load, word-store or read-modify-write path
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid && (req_load || req_store)) begin
                    if (w_req_err)                  w_next = RESP;
                    else if (req_load)              w_next = LD_REQ;
                    else if (req_size == SIZE_WORD) w_next = ST_REQ;
                    else                            w_next = RMW_REQ;
                end
            end
            LD_REQ:   if (mem_ready) w_next = LD_WAIT;
            LD_WAIT:  if (w_mem_hit) w_next = RESP;
            RMW_REQ:  if (mem_ready) w_next = RMW_WAIT;
            RMW_WAIT: if (w_mem_hit) w_next = ST_REQ;
            ST_REQ:   if (mem_ready) w_next = RESP;
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs decoded from state; response fields are only driven during RESP
    always_comb begin
        req_ready      = (r_state == IDLE);
        busy           = (r_state != IDLE);
        mem_load       = (r_state == LD_REQ) || (r_state == RMW_REQ);
        mem_store      = (r_state == ST_REQ);
        mem_address    = w_mem_address;
        mem_store_data = r_store_word;
        rsp_valid      = (r_state == RESP);
        rsp_data       = (r_state == RESP) ? r_rsp_data : '0;
        rsp_error      = (r_state == RESP) && r_rsp_error;
        rsp_tag        = r_tag;
    end

    // Request capture at accept, load result capture, and store-word merge for sub-word stores
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_store_word <= '0;
            r_tag        <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr       <= req_address;
                        r_size       <= req_size;
                        r_unsigned   <= req_unsigned;
                        r_store_word <= req_store_data;
                        r_tag        <= req_tag;
                        r_rsp_data   <= '0;
                        r_rsp_error  <= w_req_err;
                    end
                end
                LD_WAIT:  if (w_mem_hit) r_rsp_data   <= w_load_data;
                RMW_WAIT: if (w_mem_hit) r_store_word <= w_merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed self-checking bench for mem_access_sequencer
module tb_mem_access_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [19:0] req_address;
    logic [31:0] req_store_data;
    logic [4:0]  req_tag;
    logic        mem_load, mem_store, mem_ready, mem_valid;
    logic [19:0] mem_address, mem_data_addr;
    logic [31:0] mem_store_data, mem_load_data;
    logic        rsp_valid, rsp_error, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:15];

    int          t_cyc, t_loads, t_stores, t_unstable, t_both;
    logic        t_got, t_err;
    logic [31:0] t_data, t_st_data;
    logic [4:0]  t_tag;
    logic [19:0] t_ld_addr, t_st_addr;

    always #5 clock = ~clock;

    mem_access_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_store_data(req_store_data), .req_tag(req_tag),
        .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
        .mem_store_data(mem_store_data), .mem_ready(mem_ready), .mem_valid(mem_valid),
        .mem_load_data(mem_load_data), .mem_data_addr(mem_data_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_error(rsp_error), .busy(busy)
    );

    // Issue one request, act as memory_unit (stall_n cycles of mem_ready low), record what happens
    task automatic run_req(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [19:0] addr, input logic [31:0] sd, input logic [4:0] tag,
                           input int stall_n, input int budget);
        logic        pend, st_seen;
        logic [31:0] pdata;
        logic [19:0] paddr;
        int          st_left;
        t_cyc = 0; t_loads = 0; t_stores = 0; t_unstable = 0; t_both = 0;
        t_got = 0; t_err = 0; t_data = 0; t_st_data = 0; t_tag = 0; t_ld_addr = 0; t_st_addr = 0;
        pend = 0; st_seen = 0; pdata = 0; paddr = 0; st_left = stall_n;
        @(negedge clock);
        req_valid = 1; req_load = ld; req_store = st; req_size = sz; req_unsigned = uns;
        req_address = addr; req_store_data = sd; req_tag = tag;
        @(posedge clock);
        #1;
        req_valid = 0; req_load = 0; req_store = 0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            mem_valid = pend;
            mem_load_data = pend ? pdata : 32'd0;
            mem_data_addr = pend ? paddr : 20'd0;
            pend = 0;
            mem_ready = 0;
            if (mem_load && mem_store) t_both++;
            if (mem_load) begin
                if (st_left > 0) st_left--;
                else begin
                    mem_ready = 1; t_loads++; t_ld_addr = mem_address;
                    pend = 1; pdata = mem[mem_address[5:2]]; paddr = mem_address;
                end
            end else if (mem_store) begin
                if (!st_seen) begin
                    st_seen = 1; t_st_addr = mem_address; t_st_data = mem_store_data;
                end else if (mem_address !== t_st_addr || mem_store_data !== t_st_data) t_unstable++;
                if (st_left > 0) st_left--;
                else begin
                    mem_ready = 1; t_stores++; mem[mem_address[5:2]] = mem_store_data;
                end
            end
            if (rsp_valid) begin
                t_got = 1; t_cyc = cyc; t_data = rsp_data; t_tag = rsp_tag; t_err = rsp_error;
                break;
            end
        end
        @(posedge clock);
        #1;
        mem_ready = 0; mem_valid = 0; mem_load_data = 0; mem_data_addr = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({mem_load, mem_store, rsp_valid, rsp_error} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_load, mem_store, rsp_valid, rsp_error}); end
        checks++; if ({mem_address, mem_store_data, rsp_data, rsp_tag} !== 89'd0) begin failures++; $display("FAIL reset_buses got=%h exp=0", {mem_address, mem_store_data, rsp_data, rsp_tag}); end
        reset = 1;
    endtask

    task automatic test_load_word();
        mem[2] = 32'h1234_5678;
        run_req(1, 0, 2'd2, 0, 20'h00008, 32'd0, 5'd7, 0, 12);
        checks++; if (t_got !== 1'b1 || t_cyc != 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", t_cyc); end
        checks++; if (t_data !== 32'h1234_5678) begin failures++; $display("FAIL lw_data got=%h exp=12345678", t_data); end
        checks++; if (t_tag !== 5'd7 || t_err !== 1'b0) begin failures++; $display("FAIL lw_tag_err got=%0d/%b exp=7/0", t_tag, t_err); end
        checks++; if (t_loads != 1 || t_ld_addr !== 20'h00008) begin failures++; $display("FAIL lw_addr got=%h n=%0d exp=00008 n=1", t_ld_addr, t_loads); end
    endtask

    task automatic test_load_subword();
        mem[2] = 32'h80FF_7F01;
        run_req(1, 0, 2'd0, 0, 20'h0000B, 32'd0, 5'd3, 0, 12);
        checks++; if (t_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", t_data); end
        checks++; if (t_ld_addr !== 20'h00008) begin failures++; $display("FAIL lb_addr got=%h exp=00008", t_ld_addr); end
        run_req(1, 0, 2'd0, 1, 20'h0000B, 32'd0, 5'd4, 0, 12);
        checks++; if (t_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", t_data); end
        run_req(1, 0, 2'd1, 0, 20'h0000A, 32'd0, 5'd5, 0, 12);
        checks++; if (t_data !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ff", t_data); end
        run_req(1, 0, 2'd1, 1, 20'h00008, 32'd0, 5'd6, 0, 12);
        checks++; if (t_data !== 32'h0000_7F01) begin failures++; $display("FAIL lhu_data got=%h exp=00007f01", t_data); end
        run_req(1, 0, 2'd0, 0, 20'h00009, 32'd0, 5'd6, 0, 12);
        checks++; if (t_data !== 32'h0000_007F) begin failures++; $display("FAIL lb1_data got=%h exp=0000007f", t_data); end
    endtask

    task automatic test_store_subword();
        mem[1] = 32'h1122_3344;
        run_req(0, 1, 2'd0, 0, 20'h00005, 32'h0000_00AA, 5'd9, 0, 12);
        checks++; if (t_got !== 1'b1 || t_cyc != 4) begin failures++; $display("FAIL sb_latency got=%0d exp=4", t_cyc); end
        checks++; if (t_loads != 1 || t_ld_addr !== 20'h00004) begin failures++; $display("FAIL sb_rmw_load got=%h n=%0d exp=00004 n=1", t_ld_addr, t_loads); end
        checks++; if (t_stores != 1 || t_st_addr !== 20'h00004 || t_st_data !== 32'h1122_AA44) begin failures++; $display("FAIL sb_store got=%h@%h exp=1122aa44@00004", t_st_data, t_st_addr); end
        checks++; if (t_data !== 32'd0 || t_err !== 1'b0 || t_both != 0) begin failures++; $display("FAIL sb_rsp got=%h/%b/%0d exp=0/0/0", t_data, t_err, t_both); end
        run_req(1, 0, 2'd2, 0, 20'h00004, 32'd0, 5'd1, 0, 12);
        checks++; if (t_data !== 32'h1122_AA44) begin failures++; $display("FAIL sb_readback got=%h exp=1122aa44", t_data); end
        run_req(0, 1, 2'd1, 0, 20'h00006, 32'h1234_BEEF, 5'd2, 0, 12);
        checks++; if (t_st_data !== 32'hBEEF_AA44) begin failures++; $display("FAIL sh_store got=%h exp=beefaa44", t_st_data); end
    endtask

    task automatic test_store_stall();
        mem[3] = 32'h0;
        run_req(0, 1, 2'd2, 0, 20'h0000C, 32'hDEAD_BEEF, 5'd11, 3, 16);
        checks++; if (t_got !== 1'b1 || t_cyc != 5) begin failures++; $display("FAIL sw_stall_latency got=%0d exp=5", t_cyc); end
        checks++; if (t_unstable != 0) begin failures++; $display("FAIL sw_stall_stable got=%0d exp=0", t_unstable); end
        checks++; if (t_st_data !== 32'hDEAD_BEEF || t_st_addr !== 20'h0000C || t_loads != 0) begin failures++; $display("FAIL sw_store got=%h@%h loads=%0d exp=deadbeef@0000c loads=0", t_st_data, t_st_addr, t_loads); end
        checks++; if (mem[3] !== 32'hDEAD_BEEF || t_tag !== 5'd11) begin failures++; $display("FAIL sw_mem got=%h tag=%0d exp=deadbeef tag=11", mem[3], t_tag); end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [0:3];
        logic [19:0] ad [0:3];
        logic        st [0:3];
        sz[0] = 2'd1; ad[0] = 20'h00003; st[0] = 0;
        sz[1] = 2'd2; ad[1] = 20'h00006; st[1] = 0;
        sz[2] = 2'd2; ad[2] = 20'h0000C; st[2] = 1;
        sz[3] = 2'd3; ad[3] = 20'h00000; st[3] = 0;
        for (int i = 0; i < 4; i++) begin
            run_req(1, st[i], sz[i], 0, ad[i], 32'hFFFF_FFFF, 5'(20 + i), 0, 8);
            checks++; if (t_got !== 1'b1 || t_cyc != 1 || t_err !== 1'b1) begin failures++; $display("FAIL err%0d_rsp got=cyc%0d err=%b exp=cyc1 err=1", i, t_cyc, t_err); end
            checks++; if (t_loads + t_stores != 0 || t_data !== 32'd0) begin failures++; $display("FAIL err%0d_noaccess got=%0d/%h exp=0/0", i, t_loads + t_stores, t_data); end
        end
    endtask

    task automatic test_drop();
        run_req(0, 0, 2'd2, 0, 20'h00008, 32'd0, 5'd1, 0, 6);
        checks++; if (t_got !== 1'b0 || t_loads + t_stores != 0) begin failures++; $display("FAIL drop got=rsp%b acc=%0d exp=rsp0 acc=0", t_got, t_loads + t_stores); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        mem[2] = 32'h1234_5678;
        @(negedge clock);
        req_valid = 1; req_load = 1; req_store = 0; req_size = 2'd2; req_address = 20'h00008; req_tag = 5'd8;
        @(posedge clock);
        #1 req_valid = 0; req_load = 0;
        @(negedge clock);
        mem_ready = 1;
        @(posedge clock);
        @(negedge clock);
        mem_ready = 0;
        checks++; if (busy !== 1'b1 || mem_load !== 1'b0) begin failures++; $display("FAIL mid_in_wait got=busy%b ld%b exp=busy1 ld0", busy, mem_load); end
        reset = 0;
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset got=busy%b rdy%b exp=busy0 rdy1", busy, req_ready); end
        mem_valid = 1; mem_load_data = 32'h1234_5678; mem_data_addr = 20'h00008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mem_valid = 0;
            if (rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        mem[4] = 32'hCAFE_F00D;
        mem[5] = 32'h0BAD_1DEA;
        run_req(1, 0, 2'd2, 0, 20'h00010, 32'd0, 5'd12, 0, 12);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        run_req(1, 0, 2'd2, 0, 20'h00014, 32'd0, 5'd13, 0, 12);
        checks++; if (t_cyc != 3 || t_data !== 32'h0BAD_1DEA || t_tag !== 5'd13) begin failures++; $display("FAIL b2b_second got=%h cyc%0d tag%0d exp=0bad1dea cyc3 tag13", t_data, t_cyc, t_tag); end
    endtask

    initial begin
        req_valid = 0; req_load = 0; req_store = 0; req_size = 0; req_unsigned = 0;
        req_address = 0; req_store_data = 0; req_tag = 0;
        mem_ready = 0; mem_valid = 0; mem_load_data = 0; mem_data_addr = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store_subword();
        test_store_stall();
        test_errors();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
